// File: rtl/signed_unsigned_mac_if.sv
// Handshake and data bundle for signed_unsigned_mac: elastic input (a, b, c, mode, acc)
// and elastic output (answer, ovf), each with its own valid/ready pair.
interface signed_unsigned_mac_if #(
  parameter int W = 4
);
  logic           i_valid;
  logic           o_ready;
  logic [W-1:0]   i_a;
  logic [W-1:0]   i_b;
  logic [W-1:0]   i_c;
  logic           i_mode;
  logic           i_acc;
  logic           o_valid;
  logic           i_ready;
  logic [2*W-1:0] o_answer;
  logic           o_ovf;

  modport slave (
    input  i_valid, i_a, i_b, i_c, i_mode, i_acc, i_ready,
    output o_ready, o_valid, o_answer, o_ovf
  );

  modport master (
    output i_valid, i_a, i_b, i_c, i_mode, i_acc, i_ready,
    input  o_ready, o_valid, o_answer, o_ovf
  );
endinterface

// File: rtl/signed_unsigned_mac.sv
// Two-stage elastic multiply-add/accumulate: a*b+c or a*b+previous result, signed or unsigned
// per transaction. Define MAC_SAT_EN to saturate overflowed accumulations instead of wrapping.
module signed_unsigned_mac #(
  parameter int W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  signed_unsigned_mac_if.slave  bus
);
  localparam int RW = 2 * W;

  typedef struct packed {
    logic [RW-1:0] p;
    logic [RW-1:0] c;
    logic          mode;
    logic          acc;
  } s1_t;

  s1_t           s1_q, s1_d;
  logic          v1_q;
  logic          vo_q;
  logic [RW-1:0] ans_q, ans_d;
  logic          ovf_q, ovf_d;
  logic          adv2, ld1;
  logic [RW-1:0] addend;
  logic [RW:0]   sum;

  function automatic logic [RW-1:0] ext(input logic [W-1:0] x, input logic sgn);
    return sgn ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
  endfunction

  assign adv2 = !vo_q || bus.i_ready;
  assign ld1  = !i_rst && (!v1_q || adv2);

  // Truncating the 2W x 2W product to 2W bits is exact in both modes.
  always_comb begin
    s1_d.p    = ext(bus.i_a, bus.i_mode) * ext(bus.i_b, bus.i_mode);
    s1_d.c    = ext(bus.i_c, bus.i_mode);
    s1_d.mode = bus.i_mode;
    s1_d.acc  = bus.i_acc;
  end

  // The accumulator is the output register itself, so back-to-back acc needs no forwarding.
  always_comb begin
    addend = s1_q.acc ? ans_q : s1_q.c;
    sum    = {1'b0, s1_q.p} + {1'b0, addend};
    ovf_d  = 1'b0;
    if (s1_q.acc) begin
      if (s1_q.mode)
        ovf_d = (s1_q.p[RW-1] == addend[RW-1]) && (sum[RW-1] != s1_q.p[RW-1]);
      else
        ovf_d = sum[RW];
    end
    ans_d = sum[RW-1:0];
`ifdef MAC_SAT_EN
    if (ovf_d) begin
      if (!s1_q.mode)        ans_d = {RW{1'b1}};
      else if (addend[RW-1]) ans_d = {1'b1, {(RW-1){1'b0}}};
      else                   ans_d = {1'b0, {(RW-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1_q  <= 1'b0;
      s1_q  <= '0;
      vo_q  <= 1'b0;
      ans_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (ld1) begin
        v1_q <= bus.i_valid;
        if (bus.i_valid) s1_q <= s1_d;
      end
      if (adv2) begin
        vo_q <= v1_q;
        if (v1_q) begin
          ans_q <= ans_d;
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign bus.o_ready  = ld1;
  assign bus.o_valid  = vo_q;
  assign bus.o_answer = ans_q;
  assign bus.o_ovf    = ovf_q;
endmodule

// File: tb/tb_signed_unsigned_mac.sv
// Randomized and directed bench for signed_unsigned_mac (W=4) against an integer-arithmetic model.
module tb_signed_unsigned_mac;
  localparam int     W  = 4;
  localparam int     RW = 2 * W;
  localparam longint M  = 64'sd1 << RW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  signed_unsigned_mac_if #(.W(W)) bus ();
  signed_unsigned_mac #(.W(W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RW-1:0] q_ans[$];
  logic          q_ovf[$];
  longint        model_acc = 0;

  bit            in_fire, out_fire, exp_ok, got_valid, got_ordy, got_ovf, exp_ovf;
  logic [RW-1:0] got_ans, exp_ans;

  function automatic longint interp(input longint v, input int bits, input bit sgn);
    if (sgn && v >= (64'sd1 << (bits - 1))) return v - (64'sd1 << bits);
    return v;
  endfunction

  task automatic model_push(input longint a, input longint b, input longint c,
                            input bit sgn, input bit acc);
    longint s, r;
    bit     ov;
    s  = interp(a, W, sgn) * interp(b, W, sgn) +
         (acc ? interp(model_acc, RW, sgn) : interp(c, W, sgn));
    ov = acc && (sgn ? (s >= M / 2 || s < -(M / 2)) : (s >= M));
    r  = ((s % M) + M) % M;
`ifdef MAC_SAT_EN
    if (ov) r = !sgn ? M - 1 : (s > 0 ? M / 2 - 1 : M / 2);
`endif
    model_acc = r;
    q_ans.push_back(r[RW-1:0]);
    q_ovf.push_back(ov);
  endtask

  task automatic model_clear();
    model_acc = 0;
    q_ans.delete();
    q_ovf.delete();
  endtask

  // Observe the cycle at the falling edge, then let the rising edge happen.
  task automatic tick();
    @(negedge clk);
    got_valid = bus.o_valid;
    got_ordy  = bus.o_ready;
    got_ans   = bus.o_answer;
    got_ovf   = bus.o_ovf;
    out_fire  = bus.o_valid && bus.i_ready;
    in_fire   = bus.i_valid && bus.o_ready;
    exp_ok    = 1'b0;
    if (out_fire && q_ans.size() > 0) begin
      exp_ok  = 1'b1;
      exp_ans = q_ans.pop_front();
      exp_ovf = q_ovf.pop_front();
    end
    if (in_fire)
      model_push(longint'(bus.i_a), longint'(bus.i_b), longint'(bus.i_c), bus.i_mode, bus.i_acc);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input bit m, input bit ac);
    bus.i_valid = v; bus.i_a = a; bus.i_b = b; bus.i_c = c; bus.i_mode = m; bus.i_acc = ac;
  endtask

  task automatic rand_in();
    bus.i_a    = W'($urandom);
    bus.i_b    = W'($urandom);
    bus.i_c    = W'($urandom);
    bus.i_mode = 1'($urandom);
    bus.i_acc  = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
    bus.i_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.o_valid !== 1'b0 || bus.o_answer !== '0 || bus.o_ovf !== 1'b0 || bus.o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ans=%h ovf=%b rdy=%b, want 0 00 0 0",
               bus.o_valid, bus.o_answer, bus.o_ovf, bus.o_ready);
    end
    tick(); tick();
    rst = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: rdy=%b, want 1", bus.o_ready);
    end
  endtask

  task automatic test_unsigned_latency();
    bus.i_ready = 1'b1;
    set_in(1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    tick();
    bus.i_valid = 1'b0;
    tick();
    n_tests++;
    if (got_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: o_valid=%b one cycle after accept, want 0", got_valid);
    end
    tick();
    n_tests++;
    if (got_valid !== 1'b1 || got_ans !== 8'hF0 || got_ovf !== 1'b0 || !exp_ok ||
        exp_ans !== 8'hF0 || exp_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL unsigned_noacc: valid=%b ans=%h ovf=%b, want 1 f0 0", got_valid, got_ans, got_ovf);
    end
  endtask

  task automatic test_signed_noacc();
    logic [RW-1:0] ec[2];
    int k = 0;
    ec[0] = 8'h3F; ec[1] = 8'hC8;
    bus.i_ready = 1'b1;
    set_in(1'b1, 4'h8, 4'h8, 4'hF, 1'b1, 1'b0); tick();
    set_in(1'b1, 4'h7, 4'h8, 4'h0, 1'b1, 1'b0); tick();
    bus.i_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_fire) begin
        n_tests++;
        if (k > 1 || got_ans !== ec[k] || got_ovf !== 1'b0 || !exp_ok || got_ans !== exp_ans) begin
          n_fail++;
          $display("FAIL signed_noacc[%0d]: ans=%h ovf=%b, want %h 0", k, got_ans, got_ovf, ec[k % 2]);
        end
        k++;
      end
    end
    n_tests++;
    if (k != 2) begin n_fail++; $display("FAIL signed_noacc_count: got %0d results, want 2", k); end
  endtask

  task automatic test_acc_chain(input bit sgn);
    logic [W-1:0]  va[3];
    logic [RW-1:0] ea[3];
    logic          eo[3];
    int k = 0;
    int first = -1;
    if (sgn) begin
      va[0] = 4'h7; va[1] = 4'h7; va[2] = 4'h7;
`ifdef MAC_SAT_EN
      ea[0] = 8'h31; ea[1] = 8'h62; ea[2] = 8'h7F;
`else
      ea[0] = 8'h31; ea[1] = 8'h62; ea[2] = 8'h93;
`endif
    end else begin
      va[0] = 4'hF; va[1] = 4'h1; va[2] = 4'hF;
`ifdef MAC_SAT_EN
      ea[0] = 8'hE1; ea[1] = 8'hF0; ea[2] = 8'hFF;
`else
      ea[0] = 8'hE1; ea[1] = 8'hF0; ea[2] = 8'hD1;
`endif
    end
    eo[0] = 1'b0; eo[1] = 1'b0; eo[2] = 1'b1;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) set_in(1'b1, va[i], sgn ? 4'h7 : 4'hF, 4'h0, sgn, i != 0);
      else       bus.i_valid = 1'b0;
      tick();
      if (out_fire) begin
        if (first < 0) first = i;
        n_tests++;
        if (k > 2 || i != first + k || got_ans !== ea[k % 3] || got_ovf !== eo[k % 3] ||
            !exp_ok || got_ans !== exp_ans || got_ovf !== exp_ovf) begin
          n_fail++;
          $display("FAIL acc_chain(mode=%0d)[%0d]: ans=%h ovf=%b at cycle %0d, want %h %b",
                   sgn, k, got_ans, got_ovf, i, ea[k % 3], eo[k % 3]);
        end
        k++;
      end
    end
    n_tests++;
    if (k != 3) begin n_fail++; $display("FAIL acc_chain_count(mode=%0d): got %0d, want 3", sgn, k); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    bit holding = 1'b0;
    bit saw_nrdy = 1'b0;
    logic [RW-1:0] held = '0;
    rand_in();
    for (int cyc = 1; cyc <= 20; cyc++) begin
      bus.i_valid = (sent < 5);
      bus.i_ready = !(cyc >= 2 && cyc <= 5);
      tick();
      if (in_fire) begin sent++; rand_in(); end
      if (got_valid && !bus.i_ready) begin
        if (got_ordy === 1'b0) saw_nrdy = 1'b1;
        if (holding) begin
          n_tests++;
          if (got_ans !== held) begin
            n_fail++;
            $display("FAIL stall_stable: ans=%h, want held %h", got_ans, held);
          end
        end else begin
          held = got_ans;
          holding = 1'b1;
        end
      end
      if (out_fire) begin
        got++;
        n_tests++;
        if (!exp_ok || got_ans !== exp_ans || got_ovf !== exp_ovf) begin
          n_fail++;
          $display("FAIL backpressure[%0d]: ans=%h ovf=%b, want %h %b", got, got_ans, got_ovf, exp_ans, exp_ovf);
        end
      end
    end
    n_tests++;
    if (sent != 5 || got != 5 || !saw_nrdy) begin
      n_fail++;
      $display("FAIL backpressure_flow: sent=%0d got=%0d ready_dropped=%0d, want 5 5 1", sent, got, saw_nrdy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.i_valid = ($urandom_range(0, 9) < 7);
      bus.i_ready = ($urandom_range(0, 9) < 7);
      rand_in();
      tick();
      if (out_fire) begin
        n_tests++;
        if (!exp_ok || got_ans !== exp_ans || got_ovf !== exp_ovf) begin
          n_fail++;
          $display("FAIL random[%0d]: ans=%h ovf=%b, want %h %b", i, got_ans, got_ovf, exp_ans, exp_ovf);
        end
      end
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_fire) begin
        n_tests++;
        if (!exp_ok || got_ans !== exp_ans || got_ovf !== exp_ovf) begin
          n_fail++;
          $display("FAIL random_drain: ans=%h ovf=%b, want %h %b", got_ans, got_ovf, exp_ans, exp_ovf);
        end
      end
    end
    n_tests++;
    if (q_ans.size() != 0) begin
      n_fail++;
      $display("FAIL random_outstanding: %0d results never emerged, want 0", q_ans.size());
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    bus.i_ready = 1'b0;
    set_in(1'b1, 4'h3, 4'h3, 4'h1, 1'b0, 1'b0); tick();
    set_in(1'b1, 4'h2, 4'h5, 4'h1, 1'b0, 1'b0); tick();
    bus.i_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.o_valid !== 1'b0 || bus.o_answer !== '0 || bus.o_ovf !== 1'b0 || bus.o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b ans=%h ovf=%b rdy=%b, want 0 00 0 0",
               bus.o_valid, bus.o_answer, bus.o_ovf, bus.o_ready);
    end
    model_clear();
    tick();
    rst = 1'b0;
    bus.i_ready = 1'b1;
    set_in(1'b1, 4'h3, 4'h5, 4'h9, 1'b0, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_fire) begin
        n_tests++;
        if (k != 0 || got_ans !== 8'h0F || got_ovf !== 1'b0 || !exp_ok || got_ans !== exp_ans) begin
          n_fail++;
          $display("FAIL reset_then_acc[%0d]: ans=%h ovf=%b, want 0f 0", k, got_ans, got_ovf);
        end
        k++;
      end
    end
    n_tests++;
    if (k != 1) begin n_fail++; $display("FAIL reset_discard: got %0d results, want 1", k); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned_latency();
    test_signed_noacc();
    test_acc_chain(1'b0);
    test_acc_chain(1'b1);
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
